// File: rtl/caxi4i_addr_scheduler_pkg.sv
// rtl/caxi4i_addr_scheduler_pkg.sv - shared state encoding and one-hot encode helper
package caxi4i_addr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_GRANT  = 2'd2
  } schedState_t;

  // One-hot to binary index; an all-zero vector encodes as 0.
  function automatic logic [31:0] onehotToBin(input logic [31:0] oneHot);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      if (oneHot[i]) bin = bin | 32'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/caxi4i_addr_scheduler_if.sv
// rtl/caxi4i_addr_scheduler_if.sv - request, tracker and grant signals of the address scheduler
interface caxi4i_addr_scheduler_if #(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int NUM_SLAVES_WIDTH  = 2,
  parameter int MASTERID_WIDTH    = 4,
  parameter int OPEN_TRANS_WIDTH  = 2
);
  logic [NUM_MASTERS-1:0]                  reqValid;
  logic [NUM_MASTERS*MASTERID_WIDTH-1:0]   reqID;
  logic [NUM_MASTERS*NUM_SLAVES_WIDTH-1:0] reqSlaveID;
  logic [NUM_MASTERS-1:0]                  reqReady;
  logic [MASTERID_WIDTH-1:0]               currTransID;
  logic [NUM_SLAVES_WIDTH-1:0]             currTransSlaveID;
  logic                                    threadAvail;
  logic                                    threadValid;
  logic [OPEN_TRANS_WIDTH-1:0]             threadCount;
  logic [NUM_SLAVES_WIDTH-1:0]             threadSlaveID;
  logic                                    openTransInc;
  logic                                    grantValid;
  logic [NUM_MASTERS_WIDTH-1:0]            grantMaster;
  logic                                    grantReady;

  // Scheduler side.
  modport slave (
    input  reqValid, reqID, reqSlaveID, threadAvail, threadValid, threadCount, threadSlaveID, grantReady,
    output reqReady, currTransID, currTransSlaveID, openTransInc, grantValid, grantMaster
  );

  // Masters, tracker and target mux side.
  modport master (
    output reqValid, reqID, reqSlaveID, threadAvail, threadValid, threadCount, threadSlaveID, grantReady,
    input  reqReady, currTransID, currTransSlaveID, openTransInc, grantValid, grantMaster
  );
endinterface

// File: rtl/caxi4i_addr_scheduler_rr_pick.sv
// rtl/caxi4i_addr_scheduler_rr_pick.sv - combinational round-robin picker starting at rrPtr
module caxi4i_rr_pick
  import caxi4i_addr_scheduler_pkg::*;
#(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2
) (
  input  logic [NUM_MASTERS-1:0]       reqValid,
  input  logic [NUM_MASTERS_WIDTH-1:0] rrPtr,
  output logic                         found,
  output logic [NUM_MASTERS_WIDTH-1:0] index
);
  logic [NUM_MASTERS-1:0] pickOh;
  int                     cand;

  // Scan from rrPtr upward with wrap; the first requester wins.
  always_comb begin
    pickOh = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(rrPtr) + i) % NUM_MASTERS;
      if (!found && reqValid[cand[NUM_MASTERS_WIDTH-1:0]]) begin
        found = 1'b1;
        pickOh[cand[NUM_MASTERS_WIDTH-1:0]] = 1'b1;
      end
    end
  end

  assign index = NUM_MASTERS_WIDTH'(onehotToBin(32'(pickOh)));
endmodule

// File: rtl/caxi4i_addr_scheduler.sv
// rtl/caxi4i_addr_scheduler.sv - per-slave address scheduler: pick, tracker lookup, grant
module caxi4i_addr_scheduler
  import caxi4i_addr_scheduler_pkg::*;
#(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int NUM_SLAVES_WIDTH  = 2,
  parameter int MASTERID_WIDTH    = 4,
  parameter int OPEN_TRANS_MAX    = 3,
  parameter int OPEN_TRANS_WIDTH  = 2
) (
  input logic                    sysClk,
  input logic                    sysReset,
  caxi4i_addr_scheduler_if.slave bus
);
  schedState_t                  state, stateNext;
  logic [NUM_MASTERS_WIDTH-1:0] rrPtr, rrPtrNext;
  logic [NUM_MASTERS_WIDTH-1:0] selIdx, selIdxNext, selIdxInc;
  logic [MASTERID_WIDTH-1:0]    transId, transIdNext;
  logic [NUM_SLAVES_WIDTH-1:0]  transSlave, transSlaveNext;
  logic                         pickFound;
  logic [NUM_MASTERS_WIDTH-1:0] pickIdx;
  logic                         permit;
  logic                         grantValidInt;
  logic                         handshake;

  logic [MASTERID_WIDTH-1:0]    reqIdArr    [NUM_MASTERS];
  logic [NUM_SLAVES_WIDTH-1:0]  reqSlaveArr [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
    assign reqIdArr[m]    = bus.reqID[m*MASTERID_WIDTH +: MASTERID_WIDTH];
    assign reqSlaveArr[m] = bus.reqSlaveID[m*NUM_SLAVES_WIDTH +: NUM_SLAVES_WIDTH];
  end

  caxi4i_rr_pick #(
    .NUM_MASTERS       (NUM_MASTERS),
    .NUM_MASTERS_WIDTH (NUM_MASTERS_WIDTH)
  ) u_pick (
    .reqValid (bus.reqValid),
    .rrPtr    (rrPtr),
    .found    (pickFound),
    .index    (pickIdx)
  );

  // A blocked or granted master drops to the back of the round-robin order.
  assign selIdxInc = (selIdx == NUM_MASTERS_WIDTH'(NUM_MASTERS - 1)) ? '0 : selIdx + 1'b1;

  // Fresh ID needs a free slot; a live thread must stay on its slave and below the cap.
  assign permit = (!bus.threadValid && bus.threadAvail) ||
                  (bus.threadValid && (bus.threadSlaveID == transSlave) &&
                   (bus.threadCount < OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX)));

  assign grantValidInt        = (state == ST_GRANT);
  assign handshake            = grantValidInt && bus.grantReady;
  assign bus.grantValid       = grantValidInt;
  assign bus.grantMaster      = selIdx;
  assign bus.openTransInc     = handshake;
  assign bus.reqReady         = handshake ? (NUM_MASTERS'(1) << selIdx) : '0;
  assign bus.currTransID      = transId;
  assign bus.currTransSlaveID = transSlave;

  // State and latched candidate registers.
  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      state      <= ST_IDLE;
      rrPtr      <= '0;
      selIdx     <= '0;
      transId    <= '0;
      transSlave <= '0;
    end else begin
      state      <= stateNext;
      rrPtr      <= rrPtrNext;
      selIdx     <= selIdxNext;
      transId    <= transIdNext;
      transSlave <= transSlaveNext;
    end
  end

  // Next-state: pick in IDLE, judge ordering in LOOKUP, hold the offer in GRANT.
  always_comb begin
    stateNext      = state;
    rrPtrNext      = rrPtr;
    selIdxNext     = selIdx;
    transIdNext    = transId;
    transSlaveNext = transSlave;
    case (state)
      ST_IDLE: begin
        if (pickFound) begin
          selIdxNext     = pickIdx;
          transIdNext    = reqIdArr[pickIdx];
          transSlaveNext = reqSlaveArr[pickIdx];
          stateNext      = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (permit) begin
          stateNext = ST_GRANT;
        end else begin
          rrPtrNext = selIdxInc;
          stateNext = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bus.grantReady) begin
          rrPtrNext = selIdxInc;
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end
endmodule

// File: doc/caxi4i_addr_scheduler.md
# caxi4i_addr_scheduler

Per-slave-port address-channel scheduler for the AXI4 crossbar. It round-robin arbitrates address requests from NUM_MASTERS masters, looks each candidate up in the open-transaction tracker, and grants only when AXI ordering is preserved. Same-ID transactions must target the same slave, a thread slot must be free, and the open count must be below OPEN_TRANS_MAX. On grant handshake it issues the tracker increment pulse and the one-hot accept to the winning master.

## Interface
- NUM_MASTERS, 4, requesting masters
- NUM_MASTERS_WIDTH, 2, bits to encode master index
- NUM_SLAVES_WIDTH, 2, bits to encode slave number
- MASTERID_WIDTH, 4, transaction ID width (infrastructure ID + requestor ID)
- OPEN_TRANS_MAX, 3, max outstanding transactions per thread
- OPEN_TRANS_WIDTH, 2, width of open-transaction count

Ports:
- sysClk  in  1  clock; one clock domain
- sysReset  in  1  asynchronous, active-low reset
- reqValid  in  NUM_MASTERS  per-master address valid; held until reqReady
- reqID  in  NUM_MASTERS*MASTERID_WIDTH  packed per-master transaction ID, master 0 at LSBs
- reqSlaveID  in  NUM_MASTERS*NUM_SLAVES_WIDTH  packed per-master decoded target slave
- reqReady  out  NUM_MASTERS  one-hot accept, single-cycle pulse
- currTransID  out  MASTERID_WIDTH  ID presented to tracker
- currTransSlaveID  out  NUM_SLAVES_WIDTH  slave presented to tracker
- threadAvail  in  1  tracker has a free thread slot
- threadValid  in  1  tracker matched currTransID to an active thread
- threadCount  in  OPEN_TRANS_WIDTH  open count of matched thread
- threadSlaveID  in  NUM_SLAVES_WIDTH  slave of matched thread
- openTransInc  out  1  tracker increment pulse
- grantValid  out  1  address granted toward target mux
- grantMaster  out  NUM_MASTERS_WIDTH  index of granted master
- grantReady  in  1  target mux accepted granted address

## Operation
- State machine states: IDLE, LOOKUP, GRANT; registered state.
- IDLE:
  - If any reqValid, pick the first requesting index at or after rrPtr, wrapping modulo NUM_MASTERS.
  - Latch the picked index into selIdx, and its ID and slave into currTransID and currTransSlaveID.
  - Go to LOOKUP.
  - With no requests, stay in IDLE with outputs unchanged.
- LOOKUP: tracker outputs are combinational from currTransID. Compute permit as either:
  - !threadValid & threadAvail, or
  - threadValid & (threadSlaveID == currTransSlaveID) & (threadCount < OPEN_TRANS_MAX).
  - If permit, go to GRANT.
  - Otherwise set rrPtr = selIdx+1 (mod NUM_MASTERS) and return to IDLE. The blocked master is retried after the others.
- GRANT:
  - grantValid=1 and grantMaster=selIdx.
  - On grantValid & grantReady: openTransInc=1 and reqReady[selIdx]=1 in the same cycle (combinational from the handshake).
  - Same edge: rrPtr = selIdx+1, then go to IDLE.
  - grantValid holds until grantReady.
- Only this block increments the tracker, so permit cannot be invalidated between LOOKUP and GRANT. Decrements can only relax it.
- A tracker decrement in the same cycle as openTransInc is resolved by the tracker; this block does not suppress either.
- Count comparison is unsigned at OPEN_TRANS_WIDTH bits. OPEN_TRANS_MAX must be ≤ 2^OPEN_TRANS_WIDTH−1.

## Timing
- Reset values: state=IDLE, rrPtr=0, selIdx=0, currTransID=0, currTransSlaveID=0, grantValid=0, grantMaster=0, reqReady=0, openTransInc=0.
- Latency: request seen in IDLE at cycle 0, LOOKUP at cycle 1, grantValid at cycle 2. Earliest accept (reqReady/openTransInc) is cycle 2.
- Peak throughput is one grant per 3 cycles. A blocked lookup costs 2 cycles before the next pick.
- Reset asserted mid-GRANT aborts the grant: no openTransInc and no reqReady are emitted.
- NUM_MASTERS=1: rrPtr stays 0 and wrap is a no-op.

## Structure
- Shared package:
  - state encoding constants ST_IDLE, ST_LOOKUP, ST_GRANT;
  - the one-hot-to-binary encode function already used by the crossbar.
- One sub-module: caxi4i_rr_pick, combinational round-robin picker with inputs reqValid and rrPtr, and outputs found and index.
- Parent holds the FSM, registers, and permit logic.

## Test plan
- **Single master, fresh ID:** reqValid=4'b0001, ID=5, slave=2. Tracker returns threadValid=0, threadAvail=1, and grantReady=1 at cycle 2. Required: grantMaster=0 at cycle 2 plus one-cycle openTransInc and reqReady=4'b0001.
- **Round-robin:** reqValid=4'b1111 held, all permitted, grantReady tied 1. Required: grant order 0,1,2,3,0 at cycles 2,5,8,11,14.
- **Slave mismatch block:** master 1 ID=3 slave=1; tracker threadValid=1, threadSlaveID=2. Required: no grantValid, return to IDLE at cycle 2, rrPtr=2. Releasing the tracker to threadValid=0 leads to a later grant.
- **Count at max:** threadValid=1, same slave, threadCount=3 → blocked. Tracker drops threadCount to 2 → granted on the next attempt with openTransInc=1.
- **Table full:** threadValid=0, threadAvail=0 → never granted while threadAvail=0; other masters are granted meanwhile.
- **Backpressure and reset:** grantReady=0 for 5 cycles → grantValid and grantMaster stable, no openTransInc. Then assert sysReset low in GRANT → all outputs 0 next edge, state IDLE, no pulse emitted.
